// File: rtl/kernel_cc_start_token_consumer_pkg.sv
// Shared definitions for the start-token consumer: handshake bundle, token
// width default and sizing helpers for the in-flight counter and token queue.
package kernel_cc_start_token_consumer_pkg;

    localparam int TOKEN_WIDTH_DEFAULT  = 1;
    localparam int MAX_INFLIGHT_DEFAULT = 2;

    // One process-side ap_ctrl_chain interface, gathered into a single bundle.
    typedef struct packed {
        logic ap_continue;
        logic ap_ready;
        logic ap_idle;
        logic ap_done;
        logic ap_start;
    } ap_ctrl_chain_t;

    // ST_PENDING means a token has been popped and ap_start is being offered.
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } start_state_e;

    // Bits needed to hold the values 0..max_inflight.
    function automatic int cnt_width_for(input int max_inflight);
        int w;
        w = $clog2(max_inflight + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Queue pointer width: address bits plus one wrap bit.
    function automatic int ptr_width_for(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/kernel_cc_token_queue.sv
// Circular token buffer with first-word fall-through read; pointers carry an
// extra wrap bit so full and empty are told apart by pointer difference.
module kernel_cc_token_queue
    import kernel_cc_start_token_consumer_pkg::*;
#(
    parameter int DEPTH     = MAX_INFLIGHT_DEFAULT,
    parameter int WIDTH     = TOKEN_WIDTH_DEFAULT,
    parameter int PTR_WIDTH = ptr_width_for(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     din_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     dout_o,
    output logic [PTR_WIDTH-1:0] count_o
);

    localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_ONE = PTR_WIDTH'(1);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    generate
        if (DEPTH == 1) begin : g_single
            assign wr_addr = '0;
            assign rd_addr = '0;
        end else begin : g_multi
            assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
            assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_addr] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_addr];
    assign count_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/kernel_cc_start_token_consumer.sv
// Consumer end of a dataflow start-token channel: pops start tokens, drives the
// ap_ctrl_chain handshake of one process and forwards finished tokens onward.
module kernel_cc_start_token_consumer
    import kernel_cc_start_token_consumer_pkg::*;
#(
    parameter int DATA_WIDTH   = TOKEN_WIDTH_DEFAULT,
    parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT,
    parameter int CNT_WIDTH    = cnt_width_for(MAX_INFLIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty_n,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_read,
    output logic                  fifo_read_ce,
    output logic                  proc_ap_start,
    input  logic                  proc_ap_ready,
    input  logic                  proc_ap_done,
    input  logic                  proc_ap_idle,
    output logic                  proc_ap_continue,
    input  logic                  done_full_n,
    output logic                  done_write,
    output logic [DATA_WIDTH-1:0] done_din,
    output logic [CNT_WIDTH-1:0]  inflight,
    output logic                  all_idle,
    output logic                  err_spurious_done
);

    localparam int PTR_WIDTH = ptr_width_for(MAX_INFLIGHT);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_INFLIGHT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    start_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] token_q, token_d;
    logic [CNT_WIDTH-1:0]  inflight_q, inflight_d;
    logic                  err_q, err_d;

    ap_ctrl_chain_t        ctrl;
    logic                  pop_ok;
    logic                  start_hs;
    logic                  done_hs;
    logic [DATA_WIDTH-1:0] q_dout;
    logic [PTR_WIDTH-1:0]  unused_q_count;
    logic                  unused_idle;

    // Handshake strobes are forced low while reset is held so nothing leaks
    // to the process or the done channel during the reset cycle.
    assign ctrl = '{
        ap_continue: done_full_n && (inflight_q != '0) && !reset,
        ap_ready:    proc_ap_ready,
        ap_idle:     proc_ap_idle,
        ap_done:     proc_ap_done,
        ap_start:    (state_q == ST_PENDING) && !reset
    };

    assign pop_ok   = fifo_empty_n && (state_q == ST_IDLE) && (inflight_q < MAX_CNT) && !reset;
    assign start_hs = ctrl.ap_start && ctrl.ap_ready;
    assign done_hs  = ctrl.ap_done && ctrl.ap_continue;

    always_comb begin
        state_d    = state_q;
        token_d    = token_q;
        inflight_d = inflight_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pop_ok) begin
                    state_d = ST_PENDING;
                    token_d = fifo_dout;
                end
            end
            ST_PENDING: begin
                if (start_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A start and a done in the same cycle cancel out in the count.
        case ({start_hs, done_hs})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase

        if (ctrl.ap_done && (inflight_q == '0) && !reset) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            token_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            token_q    <= token_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    kernel_cc_token_queue #(
        .DEPTH     (MAX_INFLIGHT),
        .WIDTH     (DATA_WIDTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_token_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (start_hs),
        .din_i   (token_q),
        .pop_i   (done_hs),
        .dout_o  (q_dout),
        .count_o (unused_q_count)
    );

    // Idle status from the process is informational only.
    assign unused_idle = ctrl.ap_idle;

    assign fifo_read         = pop_ok;
    assign fifo_read_ce      = 1'b1;
    assign proc_ap_start     = ctrl.ap_start;
    assign proc_ap_continue  = ctrl.ap_continue;
    assign done_write        = done_hs;
    assign done_din          = q_dout;
    assign inflight          = inflight_q;
    assign all_idle          = (state_q == ST_IDLE) && (inflight_q == '0) && !fifo_empty_n;
    assign err_spurious_done = err_q;

endmodule

// File: tb/tb_kernel_cc_start_token_consumer.sv
// Bench for the start-token consumer: directed scenarios plus random traffic,
// each cycle compared against a queue-based model of the token flow.
module tb_kernel_cc_start_token_consumer;

    localparam int DW   = 1;
    localparam int MAXI = 2;
    localparam int CW   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty_n;
    logic [DW-1:0] fifo_dout;
    logic          fifo_read;
    logic          fifo_read_ce;
    logic          proc_ap_start;
    logic          proc_ap_ready;
    logic          proc_ap_done;
    logic          proc_ap_idle;
    logic          proc_ap_continue;
    logic          done_full_n;
    logic          done_write;
    logic [DW-1:0] done_din;
    logic [CW-1:0] inflight;
    logic          all_idle;
    logic          err_spurious_done;

    always #5 clk = ~clk;

    kernel_cc_start_token_consumer #(
        .DATA_WIDTH   (DW),
        .MAX_INFLIGHT (MAXI),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_empty_n      (fifo_empty_n),
        .fifo_dout         (fifo_dout),
        .fifo_read         (fifo_read),
        .fifo_read_ce      (fifo_read_ce),
        .proc_ap_start     (proc_ap_start),
        .proc_ap_ready     (proc_ap_ready),
        .proc_ap_done      (proc_ap_done),
        .proc_ap_idle      (proc_ap_idle),
        .proc_ap_continue  (proc_ap_continue),
        .done_full_n       (done_full_n),
        .done_write        (done_write),
        .done_din          (done_din),
        .inflight          (inflight),
        .all_idle          (all_idle),
        .err_spurious_done (err_spurious_done)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Environment and reference model state.
    logic [DW-1:0] up_q[$];   // upstream start FIFO contents, head first
    logic [DW-1:0] exp_q[$];  // started-but-not-done tokens, oldest first
    bit            m_pending;
    logic [DW-1:0] m_token;
    bit            m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_up();
        fifo_empty_n = (up_q.size() != 0);
        fifo_dout    = (up_q.size() != 0) ? up_q[0] : '0;
    endtask

    // One clock cycle: check every output against the model, then advance it.
    task automatic tick();
        bit            e_read, e_start, e_cont, e_write, e_spur;
        logic [DW-1:0] e_head;
        drive_up();
        #1;
        e_read  = !reset && (up_q.size() != 0) && !m_pending && (exp_q.size() < MAXI);
        e_start = !reset && m_pending;
        e_cont  = !reset && done_full_n && (exp_q.size() != 0);
        e_write = e_cont && proc_ap_done;
        e_spur  = !reset && proc_ap_done && (exp_q.size() == 0);
        e_head  = (exp_q.size() != 0) ? exp_q[0] : '0;
        check_eq("fifo_read", 32'(fifo_read), 32'(e_read));
        check_eq("fifo_read_ce", 32'(fifo_read_ce), 32'd1);
        check_eq("proc_ap_start", 32'(proc_ap_start), 32'(e_start));
        check_eq("proc_ap_continue", 32'(proc_ap_continue), 32'(e_cont));
        check_eq("done_write", 32'(done_write), 32'(e_write));
        if (e_write) check_eq("done_din", 32'(done_din), 32'(e_head));
        check_eq("inflight", 32'(inflight), 32'(exp_q.size()));
        check_eq("all_idle", 32'(all_idle),
                 32'(!m_pending && (exp_q.size() == 0) && (up_q.size() == 0)));
        check_eq("err_spurious_done", 32'(err_spurious_done), 32'(m_err));
        @(posedge clk);
        if (reset) begin
            m_pending = 1'b0;
            m_token   = '0;
            m_err     = 1'b0;
            exp_q.delete();
            up_q.delete();
        end else begin
            if (e_write) void'(exp_q.pop_front());
            if (e_start && proc_ap_ready) begin
                exp_q.push_back(m_token);
                m_pending = 1'b0;
            end
            if (e_spur) m_err = 1'b1;
            if (e_read) begin
                m_token   = up_q.pop_front();
                m_pending = 1'b1;
            end
        end
        @(negedge clk);
        drive_up();
    endtask

    task automatic idle_inputs();
        proc_ap_ready = 1'b0;
        proc_ap_done  = 1'b0;
        done_full_n   = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        proc_ap_idle  = 1'b1;
        m_pending     = 1'b0;
        m_token       = '0;
        m_err         = 1'b0;
        idle_inputs();
        drive_up();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        check_eq("rst_inflight", 32'(inflight), 32'd0);
        check_eq("rst_err", 32'(err_spurious_done), 32'd0);
        tick();

        // Single token: ready on the second start cycle, done five cycles on.
        up_q.push_back(1'b1);
        tick();
        tick();
        proc_ap_ready = 1'b1;
        tick();
        proc_ap_ready = 1'b0;
        check_eq("single_inflight", 32'(inflight), 32'd1);
        repeat (4) tick();
        proc_ap_done = 1'b1;
        tick();
        proc_ap_done = 1'b0;
        tick();
        check_eq("single_all_idle", 32'(all_idle), 32'd1);

        // Back-pressure: done never comes, third token stays upstream.
        up_q.push_back(1'b1);
        up_q.push_back(1'b0);
        up_q.push_back(1'b1);
        proc_ap_ready = 1'b1;
        repeat (8) tick();
        check_eq("bp_inflight", 32'(inflight), 32'd2);
        check_eq("bp_fifo_read", 32'(fifo_read), 32'd0);
        check_eq("bp_left_upstream", 32'(up_q.size()), 32'd1);

        // Reset with two in flight and a token waiting upstream.
        do_reset();
        check_eq("rst2_inflight", 32'(inflight), 32'd0);
        check_eq("rst2_start", 32'(proc_ap_start), 32'd0);

        // Done stall under done-channel back-pressure.
        up_q.push_back(1'b1);
        proc_ap_ready = 1'b1;
        repeat (3) tick();
        proc_ap_ready = 1'b0;
        proc_ap_done  = 1'b1;
        done_full_n   = 1'b0;
        repeat (4) tick();
        check_eq("stall_inflight", 32'(inflight), 32'd1);
        done_full_n = 1'b1;
        tick();
        proc_ap_done = 1'b0;
        check_eq("stall_release_inflight", 32'(inflight), 32'd0);

        // Simultaneous start and done handshakes.
        do_reset();
        up_q.push_back(1'b0);
        up_q.push_back(1'b1);
        proc_ap_ready = 1'b1;
        tick();
        tick();
        proc_ap_ready = 1'b0;
        tick();
        check_eq("sim_pending", 32'(proc_ap_start), 32'd1);
        proc_ap_ready = 1'b1;
        proc_ap_done  = 1'b1;
        tick();
        check_eq("sim_inflight", 32'(inflight), 32'd1);
        proc_ap_ready = 1'b0;
        tick();
        proc_ap_done = 1'b0;
        tick();

        // Reset while a start is pending and one invocation is in flight.
        up_q.push_back(1'b1);
        up_q.push_back(1'b0);
        proc_ap_ready = 1'b1;
        tick();
        tick();
        proc_ap_ready = 1'b0;
        tick();
        do_reset();
        check_eq("rst3_inflight", 32'(inflight), 32'd0);

        // Spurious done is sticky until reset.
        proc_ap_done = 1'b1;
        tick();
        proc_ap_done = 1'b0;
        repeat (3) tick();
        check_eq("spur_err", 32'(err_spurious_done), 32'd1);
        do_reset();
        check_eq("spur_err_cleared", 32'(err_spurious_done), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if (up_q.size() < 4 && $urandom_range(0, 1) == 1) up_q.push_back(DW'($urandom));
            proc_ap_ready = ($urandom_range(0, 2) != 0);
            if (exp_q.size() != 0) proc_ap_done = ($urandom_range(0, 2) == 0);
            else                   proc_ap_done = ($urandom_range(0, 60) == 0);
            done_full_n   = ($urandom_range(0, 3) != 0);
            proc_ap_idle  = $urandom_range(0, 1) == 1;
            reset         = ($urandom_range(0, 250) == 0);
            tick();
            reset = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
